// File: rtl/roi_pkg.sv
// Shared types and coordinate field layout for the ROI command scheduler.
package roi_pkg;

  typedef enum logic [1:0] {
    BOUNDARY,
    BYPASS,
    ACTIVE
  } roi_state_e;

  localparam int unsigned X_LSB = 16;
  localparam int unsigned X_MSB = 26;
  localparam int unsigned Y_MSB = 9;
  localparam int unsigned X_W   = X_MSB - X_LSB + 1;
  localparam int unsigned Y_W   = Y_MSB + 1;

  // Bits of a coordinate word that must be zero
  localparam logic [31:0] RSV_MASK = 32'hF800_FC00;

  // Normalised crop window: (x0,y0) top-left, (x1,y1) bottom-right
  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
  } roi_win_t;

endpackage

// File: rtl/roi_cmd_fifo.sv
// Synchronous command FIFO; count is registered so a push is visible one cycle later.
module roi_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/roi_sched.sv
// Frame-synchronous ROI command scheduler: round-robin intake, validation,
// normalisation and per-frame loading of cropper coordinates.
module roi_sched
  import roi_pkg::*;
#(
  parameter int unsigned WIDTH     = 800,
  parameter int unsigned HEIGHT    = 600,
  parameter int unsigned BIT_COORD = 32,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*BIT_COORD-1:0]   req_xy0_i,
  input  logic [NUM_REQ*BIT_COORD-1:0]   req_xy1_i,
  input  logic                           tvalid_i,
  input  logic                           tlast_i,
  input  logic                           roi_tlast_i,
  output logic [BIT_COORD-1:0]           xy_0_o,
  output logic [BIT_COORD-1:0]           xy_1_o,
  output logic                           roi_en_o,
  output logic                           done_o,
  output logic                           miss_o,
  output logic [ID_W-1:0]                id_o,
  output logic                           err_o
);

  localparam int unsigned ENT_W = $bits(roi_win_t) + ID_W;

  roi_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, cur_id_q, cur_id_d, id_q, id_d, grant_id, head_id;
  logic [BIT_COORD-1:0] xy0_q, xy0_d, xy1_q, xy1_d, xy0_in, xy1_in;
  logic                 roi_en_q, roi_en_d, roi_seen_q, roi_seen_d;
  logic                 done_q, done_d, miss_q, miss_d, err_q, err_d;
  logic                 grant_vld, hs, bad, pop, frame_end;
  logic                 fifo_full, fifo_empty;
  logic [X_W-1:0]       xa, xb;
  logic [Y_W-1:0]       ya, yb;
  roi_win_t             win, head_win;
  logic [ENT_W-1:0]     fifo_head;

  function automatic logic [BIT_COORD-1:0] pack_xy(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    pack_xy = '0;
    pack_xy[X_MSB:X_LSB] = x;
    pack_xy[Y_MSB:0]     = y;
  endfunction

  // Round-robin grant: first valid requester at or after the pointer
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_vld && req_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld && !fifo_full && !rst_i) req_ready_o[grant_id] = 1'b1;
  end

  assign hs     = |(req_ready_o & req_valid_i);
  assign ptr_d  = hs ? ID_W'((32'(grant_id) + 1) % NUM_REQ) : ptr_q;
  assign xy0_in = req_xy0_i[32'(grant_id)*BIT_COORD +: BIT_COORD];
  assign xy1_in = req_xy1_i[32'(grant_id)*BIT_COORD +: BIT_COORD];
  assign xa     = xy0_in[X_MSB:X_LSB];
  assign ya     = xy0_in[Y_MSB:0];
  assign xb     = xy1_in[X_MSB:X_LSB];
  assign yb     = xy1_in[Y_MSB:0];

  assign bad = (32'(xa) >= WIDTH) || (32'(xb) >= WIDTH) ||
               (32'(ya) >= HEIGHT) || (32'(yb) >= HEIGHT) ||
               (|(xy0_in & BIT_COORD'(RSV_MASK))) || (|(xy1_in & BIT_COORD'(RSV_MASK)));
  assign err_d = hs && bad;

  always_comb begin
    win.x0 = (xa < xb) ? xa : xb;
    win.x1 = (xa < xb) ? xb : xa;
    win.y0 = (ya < yb) ? ya : yb;
    win.y1 = (ya < yb) ? yb : ya;
  end

  roi_cmd_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs && !bad),
    .data_i  ({grant_id, win}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign head_win  = fifo_head[$bits(roi_win_t)-1:0];
  assign head_id   = fifo_head[ENT_W-1 -: ID_W];
  assign frame_end = tvalid_i && tlast_i;

  // Frame FSM; a pop always reloads the window and enters ACTIVE
  always_comb begin
    state_d    = state_q;
    roi_en_d   = roi_en_q;
    roi_seen_d = roi_seen_q;
    cur_id_d   = cur_id_q;
    xy0_d      = xy0_q;
    xy1_d      = xy1_q;
    done_d     = 1'b0;
    miss_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      BOUNDARY: begin
        if (tvalid_i)         state_d = BYPASS;
        else if (!fifo_empty) pop = 1'b1;
      end
      BYPASS: begin
        if (frame_end && !fifo_empty) pop = 1'b1;
      end
      ACTIVE: begin
        if (roi_tlast_i && !roi_seen_q) begin
          done_d     = 1'b1;
          roi_seen_d = 1'b1;
        end
        if (frame_end) begin
          if (!roi_seen_q && !roi_tlast_i) miss_d = 1'b1;
          if (fifo_empty) begin
            state_d  = BYPASS;
            roi_en_d = 1'b0;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = BOUNDARY;
    endcase
    if (pop) begin
      state_d    = ACTIVE;
      roi_en_d   = 1'b1;
      roi_seen_d = 1'b0;
      cur_id_d   = head_id;
      xy0_d      = pack_xy(head_win.x0, head_win.y0);
      xy1_d      = pack_xy(head_win.x1, head_win.y1);
    end
    id_d = id_q;
    if (done_d || miss_d) id_d = cur_id_q;
    else if (err_d)       id_d = grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOUNDARY;
      ptr_q      <= '0;
      cur_id_q   <= '0;
      id_q       <= '0;
      xy0_q      <= '0;
      xy1_q      <= '0;
      roi_en_q   <= 1'b0;
      roi_seen_q <= 1'b0;
      done_q     <= 1'b0;
      miss_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_id_q   <= cur_id_d;
      id_q       <= id_d;
      xy0_q      <= xy0_d;
      xy1_q      <= xy1_d;
      roi_en_q   <= roi_en_d;
      roi_seen_q <= roi_seen_d;
      done_q     <= done_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
    end
  end

  assign xy_0_o   = xy0_q;
  assign xy_1_o   = xy1_q;
  assign roi_en_o = roi_en_q;
  assign done_o   = done_q;
  assign miss_o   = miss_q;
  assign err_o    = err_q;
  assign id_o     = id_q;

endmodule
